// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Hack CPU execute-stage branch resolver: flags, jjj condition,
//          registered PC load, multi-cycle flush and saturating counters.
// Rev    : 1.0
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH            = 16,
    parameter int CNT_WIDTH        = 16,
    parameter int REGISTERED_FLAGS = 0,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic [WIDTH-1:0]     a_reg,
    input  logic [2:0]           jjj,
    input  logic                 br_valid,
    input  logic                 flag_we,
    input  logic                 stall,
    input  logic                 cnt_clr,
    output logic                 pc_load,
    output logic [WIDTH-1:0]     pc_target,
    output logic                 flush,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] eval_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYCLES);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]      state;
    logic [FC_W-1:0] flush_cnt;
    logic            flag_zr;
    logic            flag_ng;
    logic            live_zr;
    logic            live_ng;
    logic            use_zr;
    logic            use_ng;
    logic            cond;
    logic            evaluate;
    logic            taken;
    logic            eval_inc;

    assign live_zr = (alu_out == '0);
    assign live_ng = alu_out[WIDTH-1];

    // Registered mode sees the flags as they were before this edge
    assign use_zr = (REGISTERED_FLAGS != 0) ? flag_zr : live_zr;
    assign use_ng = (REGISTERED_FLAGS != 0) ? flag_ng : live_ng;

    always_comb begin
        cond = 1'b0;
        case (jjj)
            3'b000:  cond = 1'b0;
            3'b001:  cond = ~use_zr & ~use_ng;
            3'b010:  cond = use_zr;
            3'b011:  cond = ~use_ng;
            3'b100:  cond = use_ng;
            3'b101:  cond = ~use_zr;
            3'b110:  cond = use_zr | use_ng;
            default: cond = 1'b1;
        endcase
    end

    assign evaluate = br_valid & ~stall & (state == ST_IDLE);
    assign taken    = evaluate & cond;
    assign eval_inc = evaluate & (jjj != 3'b000);

    assign flush = (state == ST_FLUSH);
    assign busy  = (state == ST_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_zr <= 1'b1;
            flag_ng <= 1'b0;
        end else if (flag_we) begin
            flag_zr <= live_zr;
            flag_ng <= live_ng;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_load   <= 1'b0;
            pc_target <= '0;
        end else begin
            pc_load <= taken;
            if (taken) begin
                pc_target <= a_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (taken) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_INIT;
                    end
                end
                default: begin
                    if (!stall) begin
                        if (flush_cnt <= FC_W'(1)) begin
                            state     <= ST_IDLE;
                            flush_cnt <= '0;
                        end else begin
                            flush_cnt <= flush_cnt - FC_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else begin
            if (eval_inc && (eval_cnt != '1)) begin
                eval_cnt <= eval_cnt + CNT_WIDTH'(1);
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_resolve_unit
// Brief  : Directed self-checking bench; dut0 uses live flags / 3-cycle
//          flush, dut1 uses registered flags / 2-cycle flush.
// Rev    : 1.0
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] alu_out = '0;
    logic [15:0] a_reg = '0;
    logic [2:0]  jjj = '0;
    logic        br_valid = 1'b0;
    logic        flag_we = 1'b0;
    logic        stall = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        pc_load0, flush0, busy0;
    logic [15:0] pc_target0;
    logic [3:0]  eval_cnt0, taken_cnt0;
    logic        pc_load1, flush1, busy1;
    logic [15:0] pc_target1;
    logic [3:0]  eval_cnt1, taken_cnt1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(16), .CNT_WIDTH(4), .REGISTERED_FLAGS(0), .FLUSH_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst), .alu_out(alu_out), .a_reg(a_reg), .jjj(jjj),
        .br_valid(br_valid), .flag_we(flag_we), .stall(stall), .cnt_clr(cnt_clr),
        .pc_load(pc_load0), .pc_target(pc_target0), .flush(flush0), .busy(busy0),
        .eval_cnt(eval_cnt0), .taken_cnt(taken_cnt0)
    );

    branch_resolve_unit #(.WIDTH(16), .CNT_WIDTH(4), .REGISTERED_FLAGS(1), .FLUSH_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .alu_out(alu_out), .a_reg(a_reg), .jjj(jjj),
        .br_valid(br_valid), .flag_we(flag_we), .stall(stall), .cnt_clr(cnt_clr),
        .pc_load(pc_load1), .pc_target(pc_target1), .flush(flush1), .busy(busy1),
        .eval_cnt(eval_cnt1), .taken_cnt(taken_cnt1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs then reflect the new cycle
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    logic [15:0] alu_vals [3] = '{16'h0000, 16'h0005, 16'hFFFB};
    logic [7:0]  take_mask [3] = '{8'b1100_1100, 8'b1010_1010, 8'b1111_0000};

    initial begin
        // Reset state
        @(posedge clk); #1;
        pulse_reset();
        check_val("rst_pc_load", {31'd0, pc_load0}, 32'd0);
        check_val("rst_pc_target", {16'd0, pc_target0}, 32'd0);
        check_val("rst_flush", {31'd0, flush0}, 32'd0);
        check_val("rst_busy", {31'd0, busy0}, 32'd0);
        check_val("rst_eval_cnt", {28'd0, eval_cnt0}, 32'd0);
        check_val("rst_taken_cnt", {28'd0, taken_cnt0}, 32'd0);

        // jjj sweep against live flags
        for (int v = 0; v < 3; v++) begin
            for (int j = 0; j < 8; j++) begin
                alu_out  = alu_vals[v];
                a_reg    = 16'h0100 + 16'(v * 8 + j);
                jjj      = 3'(j);
                br_valid = 1'b1;
                step(1);
                br_valid = 1'b0;
                check_val($sformatf("sweep_v%0d_j%0d", v, j), {31'd0, pc_load0}, {31'd0, take_mask[v][j]});
                if (take_mask[v][j]) begin
                    step(3);
                    check_val($sformatf("sweep_idle_v%0d_j%0d", v, j), {31'd0, busy0}, 32'd0);
                end
            end
            if (v == 0) begin
                check_val("sweep0_eval_cnt", {28'd0, eval_cnt0}, 32'd7);
                check_val("sweep0_taken_cnt", {28'd0, taken_cnt0}, 32'd4);
                check_val("sweep0_target", {16'd0, pc_target0}, 32'h0107);
            end
        end

        // Latency and flush window, FLUSH_CYCLES=3
        pulse_reset();
        alu_out = 16'h0000; jjj = 3'b111; a_reg = 16'h1234; br_valid = 1'b1;
        step(1);
        br_valid = 1'b0; a_reg = 16'h5555;
        check_val("lat_pc_load_n1", {31'd0, pc_load0}, 32'd1);
        check_val("lat_target_n1", {16'd0, pc_target0}, 32'h1234);
        check_val("lat_flush_n1", {31'd0, flush0}, 32'd1);
        check_val("lat_busy_n1", {31'd0, busy0}, 32'd1);
        br_valid = 1'b1;
        step(1);
        br_valid = 1'b0;
        check_val("lat_pc_load_n2", {31'd0, pc_load0}, 32'd0);
        check_val("lat_flush_n2", {31'd0, flush0}, 32'd1);
        check_val("lat_target_hold", {16'd0, pc_target0}, 32'h1234);
        step(1);
        check_val("lat_flush_n3", {31'd0, flush0}, 32'd1);
        step(1);
        check_val("lat_flush_n4", {31'd0, flush0}, 32'd0);
        check_val("lat_busy_n4", {31'd0, busy0}, 32'd0);
        check_val("lat_eval_cnt", {28'd0, eval_cnt0}, 32'd1);
        check_val("lat_taken_cnt", {28'd0, taken_cnt0}, 32'd1);

        // Stall in IDLE: no evaluation
        stall = 1'b1; br_valid = 1'b1;
        step(1);
        check_val("idle_stall_pc_load", {31'd0, pc_load0}, 32'd0);
        check_val("idle_stall_busy", {31'd0, busy0}, 32'd0);
        check_val("idle_stall_eval", {28'd0, eval_cnt0}, 32'd1);
        stall = 1'b0; br_valid = 1'b0;

        // Stall inside FLUSH, FLUSH_CYCLES=2 (dut1)
        pulse_reset();
        jjj = 3'b111; br_valid = 1'b1;
        step(1);
        br_valid = 1'b0; stall = 1'b1;
        check_val("stall_flush_c1", {31'd0, flush1}, 32'd1);
        for (int c = 2; c <= 5; c++) begin
            step(1);
            check_val($sformatf("stall_flush_c%0d", c), {31'd0, flush1}, 32'd1);
        end
        stall = 1'b0;
        step(1);
        check_val("stall_flush_c6", {31'd0, flush1}, 32'd1);
        step(1);
        check_val("stall_flush_c7", {31'd0, flush1}, 32'd0);
        check_val("stall_busy_c7", {31'd0, busy1}, 32'd0);

        // Registered flags (dut1)
        pulse_reset();
        flag_we = 1'b1; alu_out = 16'h0000;
        step(1);
        alu_out = 16'h0007; br_valid = 1'b1; jjj = 3'b010;
        step(1);
        flag_we = 1'b0; br_valid = 1'b0;
        check_val("regflag_old_taken", {31'd0, pc_load1}, 32'd1);
        step(2);
        check_val("regflag_idle", {31'd0, busy1}, 32'd0);
        br_valid = 1'b1; jjj = 3'b010;
        step(1);
        br_valid = 1'b0;
        check_val("regflag_new_not_taken", {31'd0, pc_load1}, 32'd0);

        // Counter saturation with CNT_WIDTH=4 (dut0)
        pulse_reset();
        jjj = 3'b111;
        for (int k = 0; k < 20; k++) begin
            br_valid = 1'b1;
            step(1);
            br_valid = 1'b0;
            step(3);
        end
        check_val("sat_taken_cnt", {28'd0, taken_cnt0}, 32'hF);
        check_val("sat_eval_cnt", {28'd0, eval_cnt0}, 32'hF);
        br_valid = 1'b1; cnt_clr = 1'b1;
        step(1);
        br_valid = 1'b0; cnt_clr = 1'b0;
        check_val("clr_pc_load", {31'd0, pc_load0}, 32'd1);
        check_val("clr_taken_cnt", {28'd0, taken_cnt0}, 32'd0);
        check_val("clr_eval_cnt", {28'd0, eval_cnt0}, 32'd0);
        step(3);

        // Async reset mid-FLUSH
        a_reg = 16'hBEEF; br_valid = 1'b1;
        step(1);
        br_valid = 1'b0;
        check_val("arst_pre_pc_load", {31'd0, pc_load0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_flush", {31'd0, flush0}, 32'd0);
        check_val("arst_busy", {31'd0, busy0}, 32'd0);
        check_val("arst_pc_load", {31'd0, pc_load0}, 32'd0);
        check_val("arst_taken_cnt", {28'd0, taken_cnt0}, 32'd0);
        check_val("arst_pc_target", {16'd0, pc_target0}, 32'd0);
        #1 rst = 1'b0;
        step(1);
        check_val("arst_idle_busy", {31'd0, busy0}, 32'd0);
        check_val("arst_idle_pc_load", {31'd0, pc_load0}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
